// File: rtl/reg_wb_pkg.sv
// rtl/reg_wb_pkg.sv - shared widths and writeback request type
package reg_wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
  } wb_req_t;
endpackage

// File: rtl/reg_wb_scheduler_rr_arbiter.sv
// rtl/reg_wb_scheduler_rr_arbiter.sv - round-robin grant over sources 1..N_SRC-1
module rr_arbiter #(
  parameter int N_SRC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:1] req_i,
  input  logic             advance_i,
  output logic [N_SRC-1:1] gnt_o
);
  localparam int PTR_W = (N_SRC > 2) ? $clog2(N_SRC) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d, win;
  logic             found;

  // Two passes: first from the pointer upward, then wrap to the low sources.
  always_comb begin
    gnt_o = '0;
    win   = ptr_q;
    found = 1'b0;
    for (int k = 1; k < N_SRC; k++) begin
      if (!found && req_i[k] && k >= int'(ptr_q)) begin
        gnt_o[k] = 1'b1;
        win      = PTR_W'(k);
        found    = 1'b1;
      end
    end
    for (int k = 1; k < N_SRC; k++) begin
      if (!found && req_i[k] && k < int'(ptr_q)) begin
        gnt_o[k] = 1'b1;
        win      = PTR_W'(k);
        found    = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = (win == PTR_W'(N_SRC - 1)) ? PTR_W'(1) : win + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= PTR_W'(1);
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/reg_wb_scheduler.sv
// rtl/reg_wb_scheduler.sv - shares the register file write port between writeback sources
// and tracks destinations still owed by long-latency units.
module reg_wb_scheduler
  import reg_wb_pkg::*;
#(
  parameter int N_SRC        = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_SRC-1:0]            src_valid,
  output logic [N_SRC-1:0]            src_ready,
  input  logic [N_SRC*REG_ADDR_W-1:0] src_rd,
  input  logic [N_SRC*XLEN-1:0]       src_wd,
  input  logic                        alloc_valid,
  input  logic [REG_ADDR_W-1:0]       alloc_rd,
  input  logic [REG_ADDR_W-1:0]       rs1_addr,
  input  logic [REG_ADDR_W-1:0]       rs2_addr,
  output logic                        rs1_busy,
  output logic                        rs2_busy,
  output logic                        reg_w,
  output logic [REG_ADDR_W-1:0]       rd_addr,
  output logic [XLEN-1:0]             wd
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [N_SRC-1:1]      rr_gnt;
  logic                  req_other, grant0;
  wb_req_t               sel_req;
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                  reg_w_q, reg_w_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]       wd_q, wd_d;
  logic [31:0]           busy_q, busy_d;

  rr_arbiter #(.N_SRC(N_SRC)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (src_valid[N_SRC-1:1]),
    .advance_i (~grant0 & req_other),
    .gnt_o     (rr_gnt)
  );

  always_comb begin
    req_other = |src_valid[N_SRC-1:1];
    grant0    = src_valid[0] &&
                !((starve_cnt_q == CNT_W'(STARVE_LIMIT)) && req_other);
    src_ready = '0;
    if (grant0) src_ready[0] = 1'b1;
    else        src_ready[N_SRC-1:1] = rr_gnt;

    sel_req = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_ready[i]) begin
        sel_req.rd = src_rd[i*REG_ADDR_W +: REG_ADDR_W];
        sel_req.wd = src_wd[i*XLEN +: XLEN];
      end
    end

    starve_cnt_d = '0;
    if (grant0 && req_other) begin
      starve_cnt_d = (starve_cnt_q == CNT_W'(STARVE_LIMIT)) ? starve_cnt_q
                                                            : starve_cnt_q + CNT_W'(1);
    end

    // Writes to x0 still handshake but never reach the register file.
    reg_w_d   = (|src_ready) && (sel_req.rd != '0);
    rd_addr_d = reg_w_d ? sel_req.rd : rd_addr_q;
    wd_d      = reg_w_d ? sel_req.wd : wd_q;

    // Set is applied after clear so a same-edge reallocation stays busy.
    busy_d = busy_q;
    if (reg_w_q) busy_d[rd_addr_q] = 1'b0;
    if (alloc_valid && alloc_rd != '0) busy_d[alloc_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      reg_w_q      <= 1'b0;
      rd_addr_q    <= '0;
      wd_q         <= '0;
      busy_q       <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      reg_w_q      <= reg_w_d;
      rd_addr_q    <= rd_addr_d;
      wd_q         <= wd_d;
      busy_q       <= busy_d;
    end
  end

  assign reg_w    = reg_w_q;
  assign rd_addr  = rd_addr_q;
  assign wd       = wd_q;
  assign rs1_busy = busy_q[rs1_addr] & ~(reg_w_q && rd_addr_q == rs1_addr);
  assign rs2_busy = busy_q[rs2_addr] & ~(reg_w_q && rd_addr_q == rs2_addr);
endmodule

// File: tb/tb_reg_wb_scheduler.sv
// tb/tb_reg_wb_scheduler.sv - scoreboard bench for reg_wb_scheduler
module tb_reg_wb_scheduler;
  localparam int N = 3;
  localparam int STARVE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src_valid;
  logic [N-1:0]  src_ready;
  logic [N*5-1:0]  src_rd;
  logic [N*32-1:0] src_wd;
  logic          alloc_valid;
  logic [4:0]    alloc_rd, rs1_addr, rs2_addr;
  logic          rs1_busy, rs2_busy, reg_w;
  logic [4:0]    rd_addr;
  logic [31:0]   wd;

  reg_wb_scheduler #(.N_SRC(N), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
    .src_rd(src_rd), .src_wd(src_wd), .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .reg_w(reg_w), .rd_addr(rd_addr), .wd(wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [4:0]  rd;
    logic [31:0] wd;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mbusy;
  int          mcnt, mptr;
  logic        m_w;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  logic [N-1:0] obs_ready;
  logic        obs_rs1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    src_valid[i] = v;
    src_rd[i*5 +: 5] = rd;
    src_wd[i*32 +: 32] = d;
  endtask

  task automatic model_reset();
    mbusy = '0; mcnt = 0; mptr = 1; m_w = 1'b0; m_rd = '0; m_wd = '0;
    exp_q.delete();
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic cycle();
    logic [N-1:0] g;
    int win, nc, np, s;
    logic other;
    exp_t e;
    logic [31:0] nb;
    logic [4:0] a;
    #1;
    other = src_valid[1] | src_valid[2];
    g = '0;
    win = 0;
    if (src_valid[0] && !(mcnt == STARVE && other)) g = 3'b001;
    else begin
      for (int off = 0; off < N - 1; off++) begin
        int idx;
        idx = mptr + off;
        if (idx > N - 1) idx -= N - 1;
        if (g == '0 && src_valid[idx]) begin
          g = 3'(1 << idx);
          win = idx;
        end
      end
    end
    obs_ready = src_ready;
    obs_rs1 = rs1_busy;
    check("src_ready", src_ready, g);
    check("rs1_busy", rs1_busy, mbusy[rs1_addr] && !(m_w && m_rd == rs1_addr));
    check("rs2_busy", rs2_busy, mbusy[rs2_addr] && !(m_w && m_rd == rs2_addr));
    if (alloc_valid && alloc_rd != 0)
      check("alloc_legal", mbusy[alloc_rd] && !(m_w && m_rd == alloc_rd), 0);
    e.w = 1'b0; e.rd = m_rd; e.wd = m_wd;
    if (g != '0) begin
      s = g[0] ? 0 : (g[1] ? 1 : 2);
      a = src_rd[s*5 +: 5];
      if (a != 0) begin
        e.w = 1'b1; e.rd = a; e.wd = src_wd[s*32 +: 32];
      end
    end
    exp_q.push_back(e);
    nb = mbusy;
    if (m_w) nb[m_rd] = 1'b0;
    if (alloc_valid && alloc_rd != 0) nb[alloc_rd] = 1'b1;
    nc = (g[0] && other) ? ((mcnt == STARVE) ? mcnt : mcnt + 1) : 0;
    np = (g != '0 && !g[0]) ? ((win == N - 1) ? 1 : win + 1) : mptr;
    @(posedge clk);
    mbusy = nb; mcnt = nc; mptr = np; m_w = e.w; m_rd = e.rd; m_wd = e.wd;
    @(negedge clk);
    e = exp_q.pop_front();
    check("reg_w", reg_w, e.w);
    if (e.w) begin
      check("rd_addr", rd_addr, e.rd);
      check("wd", wd, e.wd);
    end
  endtask

  initial begin
    rst = 1'b1;
    src_valid = '0; src_rd = '0; src_wd = '0;
    alloc_valid = 1'b0; alloc_rd = '0; rs1_addr = '0; rs2_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_reg_w", reg_w, 0);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_wd", wd, 0);
    check("reset_ready", src_ready, 0);
    @(negedge clk);

    // Single write from source 0
    set_src(0, 1, 5'd5, 32'h1234);
    cycle();
    check("single_gnt", obs_ready, 3'b001);
    check("single_regw", reg_w, 1);
    check("single_rd", rd_addr, 5);
    check("single_wd", wd, 32'h1234);
    set_src(0, 0, 0, 0);
    cycle();
    check("single_regw_after", reg_w, 0);

    // Round-robin between sources 1 and 2
    set_src(1, 1, 5'd3, 32'h3333);
    set_src(2, 1, 5'd4, 32'h4444);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rr_gnt", obs_ready, (i % 2 == 0) ? 3'b010 : 3'b100);
      check("rr_rd", rd_addr, (i % 2 == 0) ? 5'd3 : 5'd4);
    end

    // Starvation override: four source-0 grants, then one source-1 grant
    set_src(2, 0, 0, 0);
    set_src(1, 1, 5'd10, 32'hA0);
    for (int i = 0; i < 10; i++) begin
      set_src(0, 1, 5'd11, 32'h100 + i);
      cycle();
      check("starve_gnt", obs_ready, (i == 4 || i == 9) ? 3'b010 : 3'b001);
    end
    set_src(0, 0, 0, 0);
    set_src(1, 0, 0, 0);
    cycle();

    // Scoreboard set, forwarded clear, and same-edge set-over-clear
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    cycle();
    alloc_valid = 1'b0;
    set_src(1, 1, 5'd7, 32'h77);
    cycle();
    check("sb_set", obs_rs1, 1);
    set_src(1, 0, 0, 0);
    cycle();
    check("sb_fwd_clear", obs_rs1, 0);
    cycle();
    check("sb_stays_clear", obs_rs1, 0);
    alloc_valid = 1'b1;
    cycle();
    alloc_valid = 1'b0;
    set_src(1, 1, 5'd7, 32'h88);
    cycle();
    set_src(1, 0, 0, 0);
    alloc_valid = 1'b1;
    cycle();
    check("sb_same_edge_fwd", obs_rs1, 0);
    alloc_valid = 1'b0;
    set_src(1, 1, 5'd7, 32'h99);
    cycle();
    check("sb_same_edge", obs_rs1, 1);
    set_src(1, 0, 0, 0);
    cycle();

    // x0: handshake completes, nothing written, nothing marked busy
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    set_src(1, 1, 5'd0, 32'hDEAD);
    alloc_valid = 1'b1; alloc_rd = 5'd0;
    cycle();
    check("x0_gnt", obs_ready, 3'b010);
    check("x0_regw", reg_w, 0);
    check("x0_rd_hold", rd_addr, 5'd7);
    check("x0_wd_hold", wd, 32'h99);
    check("x0_rs1_busy", rs1_busy, 0);
    set_src(1, 0, 0, 0);
    alloc_valid = 1'b0;
    cycle();

    // Reset while source 1 is being accepted
    rs1_addr = 5'd12;
    alloc_valid = 1'b1; alloc_rd = 5'd12;
    cycle();
    alloc_valid = 1'b0;
    set_src(1, 1, 5'd13, 32'h55);
    #1;
    check("rst_pre_ready", src_ready, 3'b010);
    check("rst_pre_busy", rs1_busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_regw", reg_w, 0);
    check("rst_rd_addr", rd_addr, 0);
    set_src(1, 0, 0, 0);
    #1;
    check("rst_ready", src_ready, 0);
    foreach (exp_q[i]) check("rst_q_empty", 1, 0);
    for (int i = 0; i < 4; i++) begin
      logic [4:0] idx_tab [4];
      idx_tab = '{5'd12, 5'd7, 5'd13, 5'd1};
      rs1_addr = idx_tab[i];
      #1;
      check("rst_rs1_busy", rs1_busy, 0);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    set_src(2, 1, 5'd20, 32'hABC);
    cycle();
    check("post_rst_gnt", obs_ready, 3'b100);
    check("post_rst_wd", wd, 32'hABC);
    set_src(2, 0, 0, 0);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
